ram_read_streamer: RTL and testbench
====================================

Name: ram_read_streamer

Overview:
- Single-clock read-side controller for the team's DC_RAM word memory.
- On a start pulse it issues sequential reads of a block of words: it drives ADDR and ENABLE_R on the RAM read port and captures DATA_OUT one cycle later.
- It presents the words as a valid/ready stream to downstream logic.
- It absorbs the RAM's fixed one-cycle read latency and downstream backpressure with a 2-entry output FIFO.

Parameters:
- DATA_WIDTH, 8, word width; matches word_lenght_t.
- ADDR_WIDTH, 5, RAM address width; matches ADDR_lenght_t. Addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; the RAM read clock (clk_B) is tied to this same clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address; sampled with start.
- length  in  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH; sampled with start.
- ram_addr  out  ADDR_WIDTH  to RAM ADDR.
- ram_rd_en  out  1  to RAM ENABLE_R.
- ram_data  in  DATA_WIDTH  from RAM DATA_OUT.
- data_out  out  DATA_WIDTH  stream data (FIFO head).
- data_valid  out  1  stream valid (FIFO not empty).
- data_ready  in  1  downstream accept.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the last word has been accepted downstream.

Behaviour:
- Reset values (async, immediate): state=IDLE, ram_rd_en=0, ram_addr=0, data_valid=0, data_out=0, busy=0, done=0, FIFO count=0, in-flight flag=0, remaining=0.
- States:
  - IDLE: start=1 loads cur_addr=base_addr and remaining=length. Go to RUN if length≠0, else DONE.
  - RUN: issue reads. When the last read issues (remaining becomes 0), go to DRAIN.
  - DRAIN: no issues. When the in-flight flag is 0 and the FIFO is empty, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start outside IDLE (including in DONE) is ignored; no queuing.
- Handshake: pop = data_valid & data_ready.
- Issue condition, evaluated every cycle in RUN: remaining>0 and (count + inflight − pop) < 2.
  - ram_rd_en = issue, combinational from registered state and data_ready.
  - ram_addr = cur_addr. It holds its last value when not issuing and is 0 after reset.
- On issue: cur_addr <= cur_addr+1 (wraps from 2^ADDR_WIDTH−1 to 0), remaining <= remaining−1, inflight <= 1.
  - With no issue, inflight <= 0.
- Capture: RAM data is valid the cycle after issue. At a clock edge where inflight=1, push ram_data into the FIFO.
  - Data is never sampled when inflight=0, because the RAM outputs 0 when not enabled.
- FIFO: 2 entries, in-order.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Overflow is impossible by the issue rule. An assertion must flag push with count=2 and no pop.
- Throughput: with data_ready held high, one word per cycle after the first word.
  - First-word latency: start at edge 0, first issue in cycle 1, data_valid in cycle 3.
- Backpressure: if data_ready=0, issue stops once count+inflight reaches 2. data_out and data_valid stay stable while valid and not ready.
- done fires the cycle after the final pop, not at the final issue.
- Reset mid-operation discards the FIFO, the in-flight read and the remaining count. No done pulse is produced.
- length=2^ADDR_WIDTH reads every address once, wrapping through 0 if base_addr≠0.

Test Plan:
- RAM preloaded with addr k = 8'h10+k. start with base_addr=3, length=4, data_ready=1 → ram_rd_en high 4 consecutive cycles on addrs 3,4,5,6. Stream 13,14,15,16 on consecutive cycles. done one cycle after the last pop.
- base_addr=30, length=4 (ADDR_WIDTH=5) → addrs 30,31,0,1; stream 2E,2F,10,11.
- Same as scenario 1, but data_ready=0 for the first 6 cycles after data_valid rises → at most 2 reads issued, data_out holds 13 while stalled. After release, all 4 words arrive in order with none lost or duplicated.
- length=0 → no ram_rd_en pulses, no data_valid. done one cycle after IDLE accepts start.
- rst asserted mid-stream after 2 words were accepted → all outputs zero in the same cycle, no done. A new start with base_addr=0, length=2 streams 10,11 correctly.
- start pulsed again while busy → ignored; exactly length words out, one done pulse.

Source files
------------

// File: rtl/ram_read_streamer.sv
// Streams a block of DC_RAM words out as valid/ready data. A 2-entry FIFO hides
// the one-cycle RAM read latency and downstream stalls.
module ram_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_occupancy;
  logic [1:0]            w_count_nxt;

  assign w_push      = r_inflight;
  assign w_pop       = data_valid & data_ready;
  // Slots already claimed after this cycle's pop; a new read needs one free.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == RUN) && (r_remaining != '0) && (w_occupancy < 3'd2);
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign ram_rd_en  = w_issue;
  assign ram_addr   = w_issue ? r_cur_addr : r_last_addr;
  assign data_valid = (r_count != 2'd0);
  assign data_out   = r_mem[r_rd_ptr];
  assign busy       = (r_state == RUN) || (r_state == DRAIN);
  assign done       = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cur_addr  <= base_addr;
            r_remaining <= length;
            r_state     <= (length != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (w_issue && (r_remaining == (ADDR_WIDTH+1)'(1)))
            r_state <= DRAIN;
        end
        DRAIN: begin
          // Looking at the next count lets done land right after the final pop.
          if (!r_inflight && (w_count_nxt == 2'd0))
            r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_issue) begin
        r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
        r_last_addr <= r_cur_addr;
        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
      end
      r_inflight <= w_issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= ram_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == 2'd2) && !w_pop));

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench for ram_read_streamer: table of block reads against a RAM model, a
// scoreboard of expected addresses/words, and hand-written reset sequence.
module tb_ram_read_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic [4:0] ram_addr;
  logic       ram_rd_en;
  logic [7:0] ram_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       done;

  ram_read_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [32];
  always @(posedge clk) ram_data <= ram_rd_en ? ram[ram_addr] : 8'h00;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_data_q[$];
  logic [4:0] exp_addr_q[$];
  int pops, rd_cnt, done_cnt, max_out;
  int first_rd_cyc, first_vld_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
  logic [7:0] first_w, last_w;
  logic       stall_prev;
  logic [7:0] stall_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ram_val(input int a);
    return 8'(8'h10 + (a % 32));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
      end
      if (data_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", 32'(data_valid), 1);
        check("stall_hold", 32'(data_out), 32'(stall_dat));
      end
      stall_prev = data_valid && !data_ready;
      stall_dat  = data_out;
      if (data_valid && data_ready) begin
        pops++;
        if (pops == 1) begin first_w = data_out; first_pop_cyc = cyc; end
        last_w = data_out;
        last_pop_cyc = cyc;
        if (exp_data_q.size() == 0) check("extra_word", 1, 0);
        else check("word", 32'(data_out), 32'(exp_data_q.pop_front()));
      end
      if (rd_cnt - pops > max_out) max_out = rd_cnt - pops;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_stats();
    exp_data_q.delete();
    exp_addr_q.delete();
    pops = 0; rd_cnt = 0; done_cnt = 0; max_out = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; first_pop_cyc = -1;
    last_pop_cyc = -1; done_cyc = -1;
    first_w = 8'h00; last_w = 8'h00;
  endtask

  task automatic run_block(input logic [4:0] base, input logic [5:0] len, input int stall,
                           input bit restart, input logic [7:0] exp_first,
                           input logic [7:0] exp_last);
    int t0;
    clear_stats();
    for (int k = 0; k < int'(len); k++) begin
      exp_addr_q.push_back(5'(int'(base) + k));
      exp_data_q.push_back(ram_val(int'(base) + k));
    end
    data_ready = (stall == 0);
    start = 1'b1; base_addr = base; length = len;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(len != 0));
    if (restart) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 5'd9; length = 6'd3;
      @(posedge clk); #1;
      start = 1'b0; base_addr = base; length = len;
    end
    if (stall > 0) begin
      for (int i = 0; i < 20 && !data_valid; i++) begin @(posedge clk); #1; end
      check("stall_valid_rise", 32'(data_valid), 1);
      repeat (stall) @(posedge clk);
      #1;
      check("stall_reads", 32'(rd_cnt <= 2), 1);
      check("stall_head", 32'(data_out), 32'(exp_first));
      data_ready = 1'b1;
    end
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin @(posedge clk); #1; end
    check("done_seen", 32'(done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt), 1);
    check("rd_count", 32'(rd_cnt), 32'(len));
    check("pop_count", 32'(pops), 32'(len));
    check("exp_left", 32'(exp_data_q.size() + exp_addr_q.size()), 0);
    check("busy_end", 32'(busy), 0);
    if (len == 0) begin
      check("len0_done_lat", 32'(done_cyc - t0), 0);
      check("len0_no_valid", 32'(first_vld_cyc < 0), 1);
    end else begin
      check("first_issue_lat", 32'(first_rd_cyc - t0), 0);
      check("first_valid_lat", 32'(first_vld_cyc - t0), 2);
      check("done_after_pop", 32'(done_cyc - last_pop_cyc), 1);
      check("max_outstanding", 32'(max_out <= 2), 1);
      check("first_word", 32'(first_w), 32'(exp_first));
      check("last_word", 32'(last_w), 32'(exp_last));
      if (stall == 0)
        check("throughput", 32'(last_pop_cyc - first_pop_cyc), 32'(int'(len) - 1));
    end
  endtask

  typedef struct {
    logic [4:0] base;
    logic [5:0] len;
    int         stall;
    bit         restart;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{5'd3,  6'd4,  0, 1'b0, 8'h13, 8'h16};
    vecs[1] = '{5'd30, 6'd4,  0, 1'b0, 8'h2E, 8'h11};
    vecs[2] = '{5'd3,  6'd4,  6, 1'b0, 8'h13, 8'h16};
    vecs[3] = '{5'd7,  6'd0,  0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{5'd3,  6'd4,  0, 1'b1, 8'h13, 8'h16};
    vecs[5] = '{5'd5,  6'd32, 0, 1'b0, 8'h15, 8'h14};
    vecs[6] = '{5'd0,  6'd1,  0, 1'b0, 8'h10, 8'h10};

    for (int k = 0; k < 32; k++) ram[k] = ram_val(k);
    clear_stats();
    stall_prev = 1'b0;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; data_ready = 1'b1;
    #2;
    check("rst_rd_en", 32'(ram_rd_en), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++)
      run_block(vecs[v].base, vecs[v].len, vecs[v].stall, vecs[v].restart,
                vecs[v].exp_first, vecs[v].exp_last);

    // Reset in the middle of a long block, after two words were taken.
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(5'(k));
      exp_data_q.push_back(ram_val(k));
    end
    start = 1'b1; base_addr = 5'd0; length = 6'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && pops < 2; i++) begin @(posedge clk); #1; end
    check("mid_pops", 32'(pops), 2);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", 32'(ram_rd_en), 0);
    check("mid_rst_addr", 32'(ram_addr), 0);
    check("mid_rst_valid", 32'(data_valid), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    done_cnt = 0; rd_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 0);
    check("mid_rst_no_reads", 32'(rd_cnt), 0);
    run_block(5'd0, 6'd2, 0, 1'b0, 8'h10, 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
